// File: rtl/ysyx_22040931_fetch_redirect_pkg.sv
// Shared defines for the ysyx_22040931 fetch front end.
// Holds the reset PC, bus widths and the fetch sequencer state encoding.
package ysyx_22040931_fetch_redirect_pkg;

  localparam logic [63:0] FETCH_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          FETCH_ADDR_W   = 64;
  localparam int          FETCH_INST_W   = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040931_fetch_redirect_pc_reg.sv
// Architectural fetch PC register.
// Next value selects among reset / aligned redirect target / pc+4 / hold.
module ysyx_22040931_pc_reg
  import ysyx_22040931_fetch_redirect_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // A redirect always wins over sequential advance.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = {i_target[ADDR_W-1:2], 2'b00};
    end else if (i_advance) begin
      w_pc_next = r_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22040931_fetch_redirect.sv
// Fetch sequencer: one outstanding instruction request, valid/ready delivery
// to decode, and squashing of wrong-path instructions on a taken redirect.
module ysyx_22040931_fetch_redirect
  import ysyx_22040931_fetch_redirect_pkg::*;
#(
  parameter logic [63:0] RESET_PC = FETCH_RESET_PC,
  parameter int          ADDR_W   = FETCH_ADDR_W,
  parameter int          INST_W   = FETCH_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_req_valid,
  output logic [ADDR_W-1:0] if_req_addr,
  input  logic              if_req_ready,
  input  logic              if_rsp_valid,
  input  logic [INST_W-1:0] if_rsp_inst,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              misalign_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] r_acc_addr;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_misalign;
  logic              r_stale_ok;
  logic              w_req_fire;
  logic              w_advance;
  logic              w_capture;

  assign w_req_fire = (r_state == REQ) && if_req_ready;
  assign w_advance  = (r_state == HOLD) && inst_ready && !redirect_valid;
  assign w_capture  = (r_state == WAIT) && if_rsp_valid && !redirect_valid;

  ysyx_22040931_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_redirect (redirect_valid),
    .i_target   (redirect_target),
    .i_advance  (w_advance),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DROP leaves as soon as the squashed response lands, even if a new
  // redirect arrives with it; waiting longer would hang on a response
  // that is never coming.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        if (w_req_fire) begin
          w_state_next = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_state_next = if_rsp_valid ? REQ : DROP;
        end else if (if_rsp_valid) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || inst_ready) begin
          w_state_next = REQ;
        end
      end
      DROP: begin
        if (if_rsp_valid) begin
          w_state_next = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Once accepted, the request address is frozen until the next REQ.
  always_comb begin
    if_req_valid = 1'b0;
    if_req_addr  = r_acc_addr;
    inst_valid   = 1'b0;
    case (r_state)
      IDLE:    if_req_addr = w_pc;
      REQ: begin
        if_req_valid = 1'b1;
        if_req_addr  = w_pc;
      end
      HOLD:    inst_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_addr <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_misalign <= 1'b0;
      r_stale_ok <= 1'b1;
    end else begin
      r_misalign <= redirect_valid && is_misaligned(redirect_target[1:0]);
      if (w_req_fire) begin
        r_acc_addr <= w_pc;
        r_stale_ok <= 1'b0;
      end
      if (w_capture) begin
        r_inst    <= if_rsp_inst;
        r_inst_pc <= w_pc;
      end
    end
  end

  assign inst         = r_inst;
  assign inst_pc      = r_inst_pc;
  assign misalign_err = r_misalign;

  // A response that was in flight across a reset may still land before the
  // first new request is accepted; only later strays are protocol errors.
  a_rsp_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    if_rsp_valid |-> (r_state == WAIT || r_state == DROP || r_stale_ok));

endmodule

// File: tb/tb_ysyx_22040931_fetch_redirect.sv
// Scoreboard bench for the fetch sequencer: expected request addresses and
// delivered instructions are queued by the stimulus and popped by a monitor.
module tb_ysyx_22040931_fetch_redirect;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  int          assertCount = 0;
  int          failCount   = 0;
  int          rspDelay    = 1;
  int          misalignPulses = 0;
  logic [63:0] expAddr[$];
  exp_t        expInst[$];

  ysyx_22040931_fetch_redirect dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_req_valid    (if_req_valid),
    .if_req_addr     (if_req_addr),
    .if_req_ready    (if_req_ready),
    .if_rsp_valid    (if_rsp_valid),
    .if_rsp_inst     (if_rsp_inst),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [63:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input bit deliver);
    exp_t e;
    expAddr.push_back(addr);
    if (deliver) begin
      e.pc   = addr;
      e.inst = instOf(addr);
      expInst.push_back(e);
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((expAddr.size() != 0 || expInst.size() != 0) && n < maxCycles) begin
      cycles(1);
      n++;
    end
    checkOutput("drain", 64'(expAddr.size() + expInst.size()), 64'd0);
  endtask

  // Memory model: answers each accepted request after rspDelay cycles.
  initial begin
    logic [63:0] a;
    int d;
    if_rsp_valid = 1'b0;
    if_rsp_inst  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && if_req_valid && if_req_ready) begin
        a = if_req_addr;
        d = rspDelay;
        @(posedge clk);
        repeat (d - 1) @(posedge clk);
        #1;
        if_rsp_valid = 1'b1;
        if_rsp_inst  = instOf(a);
        @(posedge clk);
        #1;
        if_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and every new instruction.
  initial begin
    logic prevValid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (misalign_err) misalignPulses++;
      if (rst_n && if_req_valid && if_req_ready) begin
        if (expAddr.size() == 0) begin
          checkOutput("req_spurious", if_req_addr, 64'hDEAD);
        end else begin
          checkOutput("req_addr", if_req_addr, expAddr.pop_front());
        end
      end
      if (inst_valid && !prevValid) begin
        if (expInst.size() == 0) begin
          checkOutput("inst_spurious", inst_pc, 64'hDEAD);
        end else begin
          e = expInst.pop_front();
          checkOutput("inst", 64'(inst), 64'(e.inst));
          checkOutput("inst_pc", inst_pc, e.pc);
        end
      end
      prevValid = inst_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    if_req_ready    = 1'b1;
    inst_ready      = 1'b0;
    cycles(2);
    checkOutput("rst_req_valid", 64'(if_req_valid), 64'd0);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_inst", 64'(inst), 64'd0);
    checkOutput("rst_inst_pc", inst_pc, 64'd0);
    checkOutput("rst_misalign", 64'(misalign_err), 64'd0);

    $display("[TB] first fetch after reset");
    applyStimulus(64'h8000_0000, 1'b1);
    rst_n = 1'b1;
    waitDrain(40);
    checkOutput("hold_valid", 64'(inst_valid), 64'd1);

    $display("[TB] decode stalls in HOLD");
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      checkOutput("stall_inst", 64'(inst), 64'h13);
      checkOutput("stall_pc", inst_pc, 64'h8000_0000);
      checkOutput("stall_req_valid", 64'(if_req_valid), 64'd0);
      checkOutput("stall_req_addr", if_req_addr, 64'h8000_0000);
    end
    applyStimulus(64'h8000_0004, 1'b1);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    waitDrain(40);

    $display("[TB] redirect while waiting for response");
    rspDelay = 4;
    applyStimulus(64'h8000_0008, 1'b0);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    cycles(1);
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_1000;
    applyStimulus(64'h8000_1000, 1'b1);
    rspDelay = 1;
    cycles(1);
    redirect_valid = 1'b0;
    checkOutput("drop_req_valid", 64'(if_req_valid), 64'd0);
    waitDrain(40);

    $display("[TB] redirect in HOLD with inst_ready");
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_2000;
    inst_ready      = 1'b1;
    applyStimulus(64'h8000_2000, 1'b1);
    cycles(1);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    checkOutput("squash_inst_valid", 64'(inst_valid), 64'd0);
    waitDrain(40);

    $display("[TB] misaligned redirect");
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_0106;
    applyStimulus(64'h8000_0104, 1'b1);
    cycles(1);
    redirect_valid = 1'b0;
    checkOutput("misalign_pulse", 64'(misalign_err), 64'd1);
    cycles(1);
    checkOutput("misalign_clear", 64'(misalign_err), 64'd0);
    waitDrain(40);

    $display("[TB] retarget before acceptance");
    if_req_ready = 1'b0;
    inst_ready   = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    checkOutput("pre_accept_addr", if_req_addr, 64'h8000_0108);
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_3000;
    cycles(1);
    redirect_valid = 1'b0;
    checkOutput("retarget_valid", 64'(if_req_valid), 64'd1);
    checkOutput("retarget_addr", if_req_addr, 64'h8000_3000);
    applyStimulus(64'h8000_3000, 1'b1);
    if_req_ready = 1'b1;
    waitDrain(40);

    $display("[TB] redirect on the handshake cycle");
    rspDelay = 2;
    applyStimulus(64'h8000_3004, 1'b0);
    applyStimulus(64'h8000_4000, 1'b1);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_4000;
    cycles(1);
    redirect_valid = 1'b0;
    rspDelay       = 1;
    checkOutput("hs_drop_valid", 64'(if_req_valid), 64'd0);
    waitDrain(40);

    $display("[TB] pc wraps at the top of the address space");
    redirect_valid  = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    cycles(1);
    redirect_valid = 1'b0;
    waitDrain(40);
    applyStimulus(64'h0, 1'b1);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    waitDrain(40);

    $display("[TB] reset during WAIT with a late response");
    rspDelay = 6;
    applyStimulus(64'h4, 1'b0);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    cycles(2);
    rst_n        = 1'b0;
    if_req_ready = 1'b0;
    #1;
    checkOutput("mid_rst_req_valid", 64'(if_req_valid), 64'd0);
    checkOutput("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("mid_rst_inst", 64'(inst), 64'd0);
    checkOutput("mid_rst_inst_pc", inst_pc, 64'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    checkOutput("restart_valid", 64'(if_req_valid), 64'd1);
    checkOutput("restart_addr", if_req_addr, 64'h8000_0000);
    checkOutput("stale_ignored", 64'(inst_valid), 64'd0);
    rspDelay = 1;
    applyStimulus(64'h8000_0000, 1'b1);
    if_req_ready = 1'b1;
    waitDrain(40);

    checkOutput("misalign_count", 64'(misalignPulses), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
